// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback (A, always wins) and the multiply/divide unit (B). B results
//   are buffered in a small FIFO and written whenever A leaves a slot free.
//   A stall is requested when the FIFO is full, when B has been denied the
//   port too long, or when ID reads a register with a buffered B write.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wb_writeEnable/regDest/result  A write request
//   mdu_valid/ready/regDest/result B result handshake
//   readAddrLeft/readAddrRight     ID read addresses (hazard check)
//   writeEnable/writeAddr/writeResult  register file write port
//   stall_req                      freeze request to the pipeline
module reg_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_writeEnable,
    input  logic [ADDR_W-1:0] wb_regDest,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_regDest,
    input  logic [DATA_W-1:0] mdu_result,
    input  logic [ADDR_W-1:0] readAddrLeft,
    input  logic [ADDR_W-1:0] readAddrRight,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeResult,
    output logic              stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr_q, fifo_addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [STV_W-1:0]             starve_q, starve_d;

    logic a_real, empty, full, b_grant, push, pop, starve;
    logic hit_left, hit_right;

    assign a_real  = wb_writeEnable && (wb_regDest != '0);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign b_grant = !a_real && !empty;
    assign pop     = b_grant;
    assign starve  = (starve_q >= STV_W'(STARVE_LIMIT));

    // Ready depends on occupancy only, so a full FIFO refuses even while popping.
    assign mdu_ready = ~rst & ~full;
    // Writes to r0 complete the handshake but are dropped.
    assign push      = mdu_valid && mdu_ready && (mdu_regDest != '0);

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = mdu_regDest;
            fifo_data_d[wr_ptr_q] = mdu_result;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || b_grant)
            starve_d = '0;
        else if (!starve)
            starve_d = starve_q + STV_W'(1);
    end

    // An entry is occupied when its distance from the read pointer is below
    // the occupancy count; stale slots are thereby excluded from matching.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        hit_left  = 1'b0;
        hit_right = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                if (readAddrLeft  != '0 && readAddrLeft  == fifo_addr_q[i]) hit_left  = 1'b1;
                if (readAddrRight != '0 && readAddrRight == fifo_addr_q[i]) hit_right = 1'b1;
            end
        end
    end

    assign stall_req = ~rst & (full | starve | hit_left | hit_right);

    always_comb begin
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeResult = '0;
        if (!rst) begin
            if (a_real) begin
                writeEnable = 1'b1;
                writeAddr   = wb_regDest;
                writeResult = wb_result;
            end else if (b_grant) begin
                writeEnable = 1'b1;
                writeAddr   = fifo_addr_q[rd_ptr_q];
                writeResult = fifo_data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule
